// File: rtl/window_3x3_gen.sv
// 3x3 sliding-window former: shifts three vertically aligned row taps into a
// 3x3 register array and flags windows that lie entirely inside one image row.
module window_3x3_gen #(
  parameter int WIDTH      = 16,
  parameter int IMG_WIDTH  = 480,
  parameter int IMG_HEIGHT = 272
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] row0,
  input  logic [WIDTH-1:0] row1,
  input  logic [WIDTH-1:0] row2,
  output logic [WIDTH-1:0] w00,
  output logic [WIDTH-1:0] w01,
  output logic [WIDTH-1:0] w02,
  output logic [WIDTH-1:0] w10,
  output logic [WIDTH-1:0] w11,
  output logic [WIDTH-1:0] w12,
  output logic [WIDTH-1:0] w20,
  output logic [WIDTH-1:0] w21,
  output logic [WIDTH-1:0] w22,
  output logic             valid_out,
  output logic             frame_done
);

  // Only IMG_HEIGHT-2 tap-rows exist: the first two image rows just fill the line buffers.
  localparam logic [8:0] COL_LAST = 9'(IMG_WIDTH - 1);
  localparam logic [8:0] ROW_LAST = 9'(IMG_HEIGHT - 3);

  logic [8:0]       col;
  logic [8:0]       row;
  logic             accept;
  logic             col_wrap;
  logic             frame_end;
  logic [WIDTH-1:0] taps [3];
  logic [WIDTH-1:0] win  [3][3];

  assign accept    = valid_in & ~clr;
  assign col_wrap  = (col == COL_LAST);
  assign frame_end = col_wrap && (row == ROW_LAST);

  assign taps[0] = row0;
  assign taps[1] = row1;
  assign taps[2] = row2;

  // Column and tap-row position of the next accepted column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_wrap) begin
        col <= '0;
        row <= frame_end ? '0 : row + 9'd1;
      end else begin
        col <= col + 9'd1;
      end
    end
  end

  // Window array: column 0 is the oldest, column 2 the newest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else if (clr) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
        win[r][2] <= taps[r];
      end
    end
  end

  // The col>=2 gate keeps windows from straddling two image rows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else if (clr) begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= accept && (col >= 9'd2);
      frame_done <= accept && frame_end;
    end
  end

  assign w00 = win[0][0];
  assign w01 = win[0][1];
  assign w02 = win[0][2];
  assign w10 = win[1][0];
  assign w11 = win[1][1];
  assign w12 = win[1][2];
  assign w20 = win[2][0];
  assign w21 = win[2][1];
  assign w22 = win[2][2];

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen with a 5x4 image; taps carry 100*tap_row + column.
module tb_window_3x3_gen;

  localparam int W  = 16;
  localparam int IW = 5;
  localparam int IH = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         clr;
  logic         valid_in;
  logic [W-1:0] row0, row1, row2;
  logic [W-1:0] w00, w01, w02, w10, w11, w12, w20, w21, w22;
  logic         valid_out;
  logic         frame_done;

  window_3x3_gen #(.WIDTH(W), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
    .clk(clk), .rst(rst), .clr(clr), .valid_in(valid_in),
    .row0(row0), .row1(row1), .row2(row2),
    .w00(w00), .w01(w01), .w02(w02),
    .w10(w10), .w11(w11), .w12(w12),
    .w20(w20), .w21(w21), .w22(w22),
    .valid_out(valid_out), .frame_done(frame_done)
  );

  // scoreboard state
  int total = 0;
  int bad   = 0;
  int n_win  = 0;
  int n_done = 0;
  int m_col  = 0;
  int m_row  = 0;
  logic [9*W-1:0] exp_q[$];
  logic [9*W-1:0] last_win;
  bit             last_ok = 1'b0;
  int base_w, base_d;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Window whose newest column is c: field R*3+C holds 100*R + (c-2+C).
  function automatic logic [9*W-1:0] win_at(input int c);
    logic [9*W-1:0] v;
    v = '0;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++)
        v[(r*3+k)*W +: W] = W'(100*r + c - 2 + k);
    return v;
  endfunction

  function automatic logic [9*W-1:0] dut_win();
    return {w22, w21, w20, w12, w11, w10, w02, w01, w00};
  endfunction

  task automatic check_win(input string tag, input logic [9*W-1:0] exp);
    logic [9*W-1:0] got;
    got = dut_win();
    for (int i = 0; i < 9; i++)
      check_eq($sformatf("%s_w%0d%0d", tag, i/3, i%3), 32'(got[i*W +: W]), 32'(exp[i*W +: W]));
  endtask

  task automatic model_reset();
    m_col = 0;
    m_row = 0;
    last_ok = 1'b0;
    exp_q.delete();
  endtask

  // driver: one clock of stimulus followed by a check just after the edge
  task automatic step(input bit v, input bit c);
    bit ev, ed;
    @(negedge clk);
    valid_in = v;
    clr      = c;
    if (v && !c) begin
      row0 = W'(m_col);
      row1 = W'(100 + m_col);
      row2 = W'(200 + m_col);
    end else begin
      row0 = W'($urandom_range(0, 999));
      row1 = W'($urandom_range(0, 999));
      row2 = W'($urandom_range(0, 999));
    end
    @(posedge clk);
    #1;
    if (c) begin
      model_reset();
      check_eq("clr_valid", 32'(valid_out), 0);
      check_eq("clr_done", 32'(frame_done), 0);
      check_win("clr", '0);
    end else if (v) begin
      ev = (m_col >= 2);
      ed = (m_row == IH-3) && (m_col == IW-1);
      if (ev) exp_q.push_back(win_at(m_col));
      last_ok  = ev;
      last_win = win_at(m_col);
      if (m_col == IW-1) begin
        m_col = 0;
        m_row = (m_row == IH-3) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
      check_eq($sformatf("valid_c%0d_r%0d", m_col, m_row), 32'(valid_out), 32'(ev));
      check_eq("frame_done", 32'(frame_done), 32'(ed));
    end else begin
      check_eq("gap_valid", 32'(valid_out), 0);
      check_eq("gap_done", 32'(frame_done), 0);
      if (last_ok) check_win("hold", last_win);
    end
    if (valid_out && exp_q.size() > 0) check_win("win", exp_q.pop_front());
    exp_q.delete();
    if (valid_out)  n_win++;
    if (frame_done) n_done++;
    valid_in = 1'b0;
    clr      = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; valid_in = 1'b0;
    row0 = '0; row1 = '0; row2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(valid_out), 0);
    check_eq("rst_done", 32'(frame_done), 0);
    check_win("rst", '0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // one continuous row, then the second tap-row which closes the frame
    base_w = n_win; base_d = n_done;
    for (int i = 0; i < IW; i++) step(1'b1, 1'b0);
    check_eq("row0_windows", 32'(n_win - base_w), 3);
    check_eq("row0_w00", 32'(w00), 2);
    check_eq("row0_w02", 32'(w02), 4);
    check_eq("row0_w20", 32'(w20), 202);
    check_eq("row0_w22", 32'(w22), 204);
    for (int i = 0; i < IW; i++) begin
      step(1'b1, 1'b0);
      if (i == 2) begin
        check_eq("row1_first_w00", 32'(w00), 0);
        check_eq("row1_first_w01", 32'(w01), 1);
        check_eq("row1_first_w02", 32'(w02), 2);
      end
    end
    check_eq("frame_windows", 32'(n_win - base_w), 6);
    check_eq("frame_dones", 32'(n_done - base_d), 1);

    // next frame starts at column 0: windows only from the third accept
    base_w = n_win;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    check_eq("restart_windows", 32'(n_win - base_w), 1);

    // clr with valid_in at col=3, then a fresh row
    step(1'b1, 1'b1);
    base_w = n_win;
    for (int i = 0; i < IW; i++) step(1'b1, 1'b0);
    check_eq("after_clr_windows", 32'(n_win - base_w), 3);

    // gapped row: every accept is followed by an idle cycle
    base_w = n_win; base_d = n_done;
    for (int i = 0; i < IW; i++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
    check_eq("gapped_windows", 32'(n_win - base_w), 3);
    check_eq("gapped_dones", 32'(n_done - base_d), 1);

    // asynchronous reset mid-row, right after a valid window
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    check_eq("pre_rst_valid", 32'(valid_out), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_valid", 32'(valid_out), 0);
    check_eq("async_rst_done", 32'(frame_done), 0);
    check_win("async_rst", '0);
    #1 rst = 1'b0;
    model_reset();
    base_w = n_win; base_d = n_done;
    for (int i = 0; i < 4*IW; i++) step(1'b1, 1'b0);
    check_eq("two_frame_windows", 32'(n_win - base_w), 12);
    check_eq("two_frame_dones", 32'(n_done - base_d), 2);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
